// File: rtl/shared_mem_arbiter_if.sv
// rtl/shared_mem_arbiter_if.sv - requester and memory port bundle for shared_mem_arbiter
interface shared_mem_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        we;
  logic [NUM_REQ-1:0]        lock;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;
  logic                      mem_en;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata;

  // master is the environment: requesters plus the memory array
  modport master (
    output req, we, lock, addr, wdata, mem_rdata,
    input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req, we, lock, addr, wdata, mem_rdata,
    output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/shared_mem_arbiter.sv
// rtl/shared_mem_arbiter.sv - round-robin arbiter with bounded lock for one shared memory port
module shared_mem_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_LOCK = 4
) (
  input logic                 clk,
  input logic                 reset,
  shared_mem_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_LOCK + 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]         state;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      owner;
  logic [CW-1:0]      cnt;
  logic [NUM_REQ-1:0] rvalid_q;
  logic [DATA_W-1:0]  rdata_q;

  logic               rr_found;
  logic [PW-1:0]      rr_idx;
  logic [PW-1:0]      rr_next;
  logic               owner_act;
  logic               win_valid;
  logic [PW-1:0]      win_idx;
  logic [NUM_REQ-1:0] gnt;
  logic [CW-1:0]      cnt_next;

  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!rr_found && bus.req[(int'(ptr) + k) % NUM_REQ]) begin
        rr_found = 1'b1;
        rr_idx   = PW'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

  assign rr_next   = (rr_idx == PW'(NUM_REQ - 1)) ? '0 : rr_idx + PW'(1);
  assign owner_act = (state == LOCKED) && bus.req[owner];
  assign win_idx   = owner_act ? owner : rr_idx;
  // reset gates the grant combinationally so nothing reaches the array while held
  assign win_valid = reset && (owner_act || rr_found);
  assign cnt_next  = cnt + CW'(1);

  always_comb begin
    gnt = '0;
    if (win_valid) gnt[win_idx] = 1'b1;
  end

  assign bus.gnt       = gnt;
  assign bus.mem_en    = win_valid;
  assign bus.mem_we    = win_valid && bus.we[win_idx];
  assign bus.mem_addr  = win_valid ? bus.addr[int'(win_idx)*ADDR_W +: ADDR_W] : '0;
  assign bus.mem_wdata = win_valid ? bus.wdata[int'(win_idx)*DATA_W +: DATA_W] : '0;
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = rdata_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      cnt      <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= '0;
      if (win_valid && !bus.we[win_idx]) begin
        rdata_q  <= bus.mem_rdata;
        rvalid_q <= gnt;
      end

      if (owner_act) begin
        // locked grants never move the round-robin pointer
        if (!bus.lock[owner] || cnt_next == CW'(MAX_LOCK)) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt_next;
        end
      end else begin
        state <= IDLE;
        cnt   <= '0;
        if (rr_found) begin
          ptr <= rr_next;
          if (bus.lock[rr_idx] && MAX_LOCK > 1) begin
            state <= LOCKED;
            owner <= rr_idx;
            cnt   <= CW'(1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_shared_mem_arbiter.sv
// tb/tb_shared_mem_arbiter.sv - self-checking bench for shared_mem_arbiter
module tb_shared_mem_arbiter;
  localparam int N  = 2;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int ML = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shared_mem_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus();

  shared_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [7:0] init_val(input logic [7:0] a);
    case (a)
      8'h00:   return 8'd10;
      8'h11:   return 8'd7;
      8'h12:   return 8'd6;
      8'hF9:   return 8'd98;
      default: return a ^ 8'h5A;
    endcase
  endfunction

  // memory array: unwritten locations read their preset contents
  logic [7:0]   mem_array [256];
  logic [255:0] mem_written = '0;
  assign bus.mem_rdata = mem_written[bus.mem_addr] ? mem_array[bus.mem_addr] : init_val(bus.mem_addr);
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) begin
      mem_array[bus.mem_addr]   <= bus.mem_wdata;
      mem_written[bus.mem_addr] <= 1'b1;
    end
  end

  typedef struct {
    logic       rst;
    logic [1:0] req, we, lock;
    logic [7:0] a0, a1, d0, d1;
    logic [1:0] gnt, rvalid;
    logic [7:0] rdata;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // reference model state
  bit         m_locked;
  int         m_owner, m_cnt, m_ptr;
  logic [7:0] m_rdata;
  logic [7:0] shadow [256];

  function automatic vec_t mk(input logic rst, input logic [1:0] rq, w, lk,
                              input logic [7:0] a0, a1, d0, d1,
                              input logic [1:0] g, rv, input logic [7:0] rd);
    vec_t v;
    v.rst = rst; v.req = rq; v.we = w; v.lock = lk;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.gnt = g; v.rvalid = rv; v.rdata = rd;
    return v;
  endfunction

  function automatic logic [7:0] addr_of(input vec_t v, input int i);
    return (i == 0) ? v.a0 : v.a1;
  endfunction

  function automatic logic [7:0] data_of(input vec_t v, input int i);
    return (i == 0) ? v.d0 : v.d1;
  endfunction

  function automatic int model_winner(input vec_t v);
    if (!v.rst) return -1;
    if (m_locked && v.req[m_owner]) return m_owner;
    for (int k = 0; k < N; k++)
      if (v.req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic vec_t model_predict(input vec_t v);
    int w;
    w = model_winner(v);
    v.gnt = (w >= 0) ? 2'(1 << w) : 2'b00;
    if (!v.rst) begin
      v.rvalid = 2'b00;
      v.rdata  = 8'h00;
    end else if (w >= 0 && !v.we[w]) begin
      v.rvalid = 2'(1 << w);
      v.rdata  = shadow[addr_of(v, w)];
    end else begin
      v.rvalid = 2'b00;
      v.rdata  = m_rdata;
    end
    return v;
  endfunction

  function automatic void model_commit(input vec_t v);
    int w;
    w = model_winner(v);
    if (!v.rst) begin
      m_locked = 0; m_owner = 0; m_cnt = 0; m_ptr = 0; m_rdata = 8'h00;
      return;
    end
    if (w >= 0) begin
      if (v.we[w]) shadow[addr_of(v, w)] = data_of(v, w);
      else         m_rdata = shadow[addr_of(v, w)];
    end
    if (m_locked && v.req[m_owner]) begin
      m_cnt++;
      if (!v.lock[m_owner] || m_cnt == ML) begin
        m_locked = 0;
        m_cnt    = 0;
      end
    end else begin
      m_locked = 0;
      m_cnt    = 0;
      if (w >= 0) begin
        m_ptr = (w + 1) % N;
        if (v.lock[w] && ML > 1) begin
          m_locked = 1; m_owner = w; m_cnt = 1;
        end
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_cycle(input vec_t v, input string tag);
    int w;
    string p;
    p = $sformatf("%s[%0d]", tag, cyc);
    reset     = v.rst;
    bus.req   = v.req;
    bus.we    = v.we;
    bus.lock  = v.lock;
    bus.addr  = {v.a1, v.a0};
    bus.wdata = {v.d1, v.d0};
    #2;
    w = v.gnt[0] ? 0 : (v.gnt[1] ? 1 : -1);
    chk({p, " gnt"}, 32'(bus.gnt), 32'(v.gnt));
    chk({p, " mem_en"}, 32'(bus.mem_en), 32'(w >= 0));
    chk({p, " mem_we"}, 32'(bus.mem_we), (w >= 0) ? 32'(v.we[w]) : 32'd0);
    chk({p, " mem_addr"}, 32'(bus.mem_addr), (w >= 0) ? 32'(addr_of(v, w)) : 32'd0);
    chk({p, " mem_wdata"}, 32'(bus.mem_wdata), (w >= 0) ? 32'(data_of(v, w)) : 32'd0);
    @(posedge clk);
    #1;
    chk({p, " rvalid"}, 32'(bus.rvalid), 32'(v.rvalid));
    chk({p, " rdata"}, 32'(bus.rdata), 32'(v.rdata));
    model_commit(v);
    cyc++;
    @(negedge clk);
  endtask

  vec_t tbl[$];
  vec_t rv;
  logic [1:0] pr, pw, pl;
  logic [7:0] pa [2];
  logic [7:0] pd [2];

  initial begin
    m_locked = 0; m_owner = 0; m_cnt = 0; m_ptr = 0; m_rdata = 8'h00;
    for (int a = 0; a < 256; a++) shadow[a] = init_val(8'(a));
    reset = 1'b0; bus.req = '0; bus.we = '0; bus.lock = '0; bus.addr = '0; bus.wdata = '0;
    @(negedge clk);

    // reset, single read, contention, locked read-modify-write, write-then-read
    tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 8'd0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 2'b00, 8'h00, 8'h12, 8'h00, 8'h00, 2'b00, 2'b00, 8'd0));
    tbl.push_back(mk(1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 8'd0));
    tbl.push_back(mk(1, 2'b01, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b01, 2'b01, 8'd10));
    tbl.push_back(mk(1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 8'd10));
    tbl.push_back(mk(1, 2'b10, 2'b00, 2'b00, 8'h00, 8'h12, 8'h00, 8'h00, 2'b10, 2'b10, 8'd6));
    tbl.push_back(mk(1, 2'b11, 2'b00, 2'b00, 8'h11, 8'h12, 8'h00, 8'h00, 2'b01, 2'b01, 8'd7));
    tbl.push_back(mk(1, 2'b11, 2'b00, 2'b00, 8'h11, 8'h12, 8'h00, 8'h00, 2'b10, 2'b10, 8'd6));
    tbl.push_back(mk(1, 2'b11, 2'b00, 2'b00, 8'h11, 8'h12, 8'h00, 8'h00, 2'b01, 2'b01, 8'd7));
    tbl.push_back(mk(1, 2'b11, 2'b00, 2'b00, 8'h11, 8'h12, 8'h00, 8'h00, 2'b10, 2'b10, 8'd6));
    tbl.push_back(mk(1, 2'b01, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b01, 2'b01, 8'd10));
    tbl.push_back(mk(1, 2'b11, 2'b00, 2'b10, 8'h20, 8'hF9, 8'h00, 8'h00, 2'b10, 2'b10, 8'd98));
    tbl.push_back(mk(1, 2'b11, 2'b10, 2'b00, 8'h20, 8'hF9, 8'h00, 8'd99, 2'b10, 2'b00, 8'd98));
    tbl.push_back(mk(1, 2'b01, 2'b00, 2'b00, 8'h20, 8'h00, 8'h00, 8'h00, 2'b01, 2'b01, 8'h7A));
    tbl.push_back(mk(1, 2'b10, 2'b00, 2'b00, 8'h00, 8'hF9, 8'h00, 8'h00, 2'b10, 2'b10, 8'd99));
    tbl.push_back(mk(1, 2'b01, 2'b01, 2'b00, 8'h40, 8'h00, 8'hC3, 8'h00, 2'b01, 2'b00, 8'd99));
    tbl.push_back(mk(1, 2'b10, 2'b00, 2'b00, 8'h00, 8'h40, 8'h00, 8'h00, 2'b10, 2'b10, 8'hC3));
    foreach (tbl[i]) run_cycle(tbl[i], "tbl");

    // lock timeout: four grants to req0, then req1
    for (int i = 0; i < 4; i++)
      run_cycle(mk(1, 2'b11, 2'b00, 2'b01, 8'h11, 8'h12, 8'h00, 8'h00, 2'b01, 2'b01, 8'd7), "timeout");
    run_cycle(mk(1, 2'b11, 2'b00, 2'b01, 8'h11, 8'h12, 8'h00, 8'h00, 2'b10, 2'b10, 8'd6), "timeout");

    // locked owner stops requesting: released in the same cycle
    run_cycle(mk(1, 2'b11, 2'b00, 2'b01, 8'h11, 8'h12, 8'h00, 8'h00, 2'b01, 2'b01, 8'd7), "drop");
    run_cycle(mk(1, 2'b10, 2'b00, 2'b00, 8'h11, 8'h12, 8'h00, 8'h00, 2'b10, 2'b10, 8'd6), "drop");
    run_cycle(mk(1, 2'b01, 2'b00, 2'b00, 8'h11, 8'h12, 8'h00, 8'h00, 2'b01, 2'b01, 8'd7), "drop");
    run_cycle(mk(1, 2'b10, 2'b00, 2'b00, 8'h11, 8'h12, 8'h00, 8'h00, 2'b10, 2'b10, 8'd6), "drop");

    // reset during the second locked access
    run_cycle(mk(1, 2'b11, 2'b00, 2'b01, 8'h11, 8'h12, 8'h00, 8'h00, 2'b01, 2'b01, 8'd7), "rstlock");
    run_cycle(mk(0, 2'b11, 2'b00, 2'b01, 8'h11, 8'h12, 8'h00, 8'h00, 2'b00, 2'b00, 8'd0), "rstlock");
    run_cycle(mk(1, 2'b11, 2'b00, 2'b00, 8'h11, 8'h12, 8'h00, 8'h00, 2'b01, 2'b01, 8'd7), "rstlock");

    // randomized traffic against the reference model
    pr = 2'b00; pw = 2'b00; pl = 2'b00;
    for (int i = 0; i < N; i++) begin pa[i] = 8'h00; pd[i] = 8'h00; end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (pr[i] && $urandom_range(0, 19) == 0) begin
          pr[i] = 1'b0;
        end else if (!pr[i]) begin
          pr[i] = ($urandom_range(0, 3) != 0);
          pw[i] = ($urandom_range(0, 2) == 0);
          pl[i] = ($urandom_range(0, 2) == 0);
          pa[i] = 8'($urandom_range(0, 15));
          pd[i] = 8'($urandom);
        end
      end
      rv = mk(($urandom_range(0, 99) != 0), pr, pw, pl, pa[0], pa[1], pd[0], pd[1],
              2'b00, 2'b00, 8'h00);
      rv = model_predict(rv);
      run_cycle(rv, "rand");
      for (int i = 0; i < N; i++) if (rv.gnt[i]) pr[i] = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
